// File: rtl/rle_text_decoder.sv
// rle_text_decoder: expands (char, count, eol) RLE pairs into a one-beat-per-
// character stream with newline beats, tracking column/line position.
module rle_text_decoder #(
    parameter int CHAR_W   = 8,
    parameter int COUNT_W  = 8,
    parameter int LINE_W   = 12,
    parameter int MAX_COLS = 128
) (
    input  logic               iclk,
    input  logic               ireset,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [CHAR_W-1:0]  s_char,
    input  logic [COUNT_W-1:0] s_count,
    input  logic               s_eol,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [CHAR_W-1:0]  m_char,
    output logic               m_eol,
    output logic [15:0]        o_col,
    output logic [LINE_W-1:0]  o_line,
    output logic               o_err_ovf,
    output logic               o_busy
);

    localparam logic [CHAR_W-1:0]  NL_CHAR  = CHAR_W'(10);
    localparam logic [15:0]        COL_LIM  = 16'(MAX_COLS);
    localparam logic [15:0]        COL_MAX  = 16'hFFFF;
    localparam logic [COUNT_W-1:0] REM_ONE  = COUNT_W'(1);
    localparam logic [COUNT_W-1:0] REM_ZERO = '0;

    typedef enum logic [1:0] {IDLE, RUN, NL} state_t;

    state_t             state_reg, state_next;
    logic [COUNT_W-1:0] rem_reg, rem_next;
    logic [CHAR_W-1:0]  char_reg, char_next;
    logic               eol_reg, eol_next;
    logic               m_valid_reg, m_valid_next;
    logic [CHAR_W-1:0]  m_char_reg, m_char_next;
    logic               m_eol_reg, m_eol_next;
    logic [15:0]        col_reg;
    logic [LINE_W-1:0]  line_reg;
    logic               ovf_reg;
    logic               beat_acc;
    logic               load_ok;

    assign beat_acc = m_valid_reg && m_ready;

    // Next-state / output-register logic; load_ok marks a cycle where a new pair may be taken
    always_comb begin
        state_next   = state_reg;
        rem_next     = rem_reg;
        char_next    = char_reg;
        eol_next     = eol_reg;
        m_valid_next = m_valid_reg;
        m_char_next  = m_char_reg;
        m_eol_next   = m_eol_reg;
        load_ok      = 1'b0;

        case (state_reg)
            IDLE: begin
                load_ok = 1'b1;
            end
            RUN: begin
                if (beat_acc) begin
                    if (rem_reg > REM_ONE) begin
                        rem_next = rem_reg - REM_ONE;
                    end else if (eol_reg) begin
                        // Newline follows the run; input stays blocked until it is taken
                        m_char_next = NL_CHAR;
                        m_eol_next  = 1'b1;
                        state_next  = NL;
                    end else begin
                        load_ok      = 1'b1;
                        m_valid_next = 1'b0;
                        state_next   = IDLE;
                    end
                end
            end
            NL: begin
                if (beat_acc) begin
                    load_ok      = 1'b1;
                    m_valid_next = 1'b0;
                    state_next   = IDLE;
                end
            end
            default: begin
                state_next   = IDLE;
                m_valid_next = 1'b0;
            end
        endcase

        // A pair taken here overrides the fall-back to IDLE, giving bubble-free output
        if (load_ok && s_valid && !ireset) begin
            if (s_count != REM_ZERO) begin
                char_next    = s_char;
                rem_next     = s_count;
                eol_next     = s_eol;
                m_valid_next = 1'b1;
                m_char_next  = s_char;
                m_eol_next   = 1'b0;
                state_next   = RUN;
            end else if (s_eol) begin
                m_valid_next = 1'b1;
                m_char_next  = NL_CHAR;
                m_eol_next   = 1'b1;
                state_next   = NL;
            end else begin
                m_valid_next = 1'b0;
                state_next   = IDLE;
            end
        end
    end

    // State, run registers and the presented output beat
    always_ff @(posedge iclk) begin
        if (ireset) begin
            state_reg   <= IDLE;
            rem_reg     <= '0;
            char_reg    <= '0;
            eol_reg     <= 1'b0;
            m_valid_reg <= 1'b0;
            m_char_reg  <= '0;
            m_eol_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            rem_reg     <= rem_next;
            char_reg    <= char_next;
            eol_reg     <= eol_next;
            m_valid_reg <= m_valid_next;
            m_char_reg  <= m_char_next;
            m_eol_reg   <= m_eol_next;
        end
    end

    // Column/line position and sticky overflow, advanced only on accepted beats
    always_ff @(posedge iclk) begin
        if (ireset) begin
            col_reg  <= '0;
            line_reg <= '0;
            ovf_reg  <= 1'b0;
        end else if (beat_acc) begin
            if (m_eol_reg) begin
                line_reg <= line_reg + 1'b1;
                col_reg  <= '0;
            end else begin
                if (col_reg != COL_MAX) begin
                    col_reg <= col_reg + 16'd1;
                end
                if (col_reg == COL_LIM) begin
                    ovf_reg <= 1'b1;
                end
            end
        end
    end

    assign s_ready   = !ireset && load_ok;
    assign m_valid   = m_valid_reg;
    assign m_char    = m_char_reg;
    assign m_eol     = m_eol_reg;
    assign o_col     = col_reg;
    assign o_line    = line_reg;
    assign o_err_ovf = ovf_reg;
    assign o_busy    = (state_reg != IDLE);

endmodule

// File: tb/tb_rle_text_decoder.sv
// Directed testbench for rle_text_decoder (built with MAX_COLS=8 so the
// overflow flag is reachable with short lines).
module tb_rle_text_decoder;

    localparam int CHAR_W   = 8;
    localparam int COUNT_W  = 8;
    localparam int LINE_W   = 12;
    localparam int MAX_COLS = 8;

    logic               iclk;
    logic               ireset;
    logic               s_valid;
    logic               s_ready;
    logic [CHAR_W-1:0]  s_char;
    logic [COUNT_W-1:0] s_count;
    logic               s_eol;
    logic               m_valid;
    logic               m_ready;
    logic [CHAR_W-1:0]  m_char;
    logic               m_eol;
    logic [15:0]        o_col;
    logic [LINE_W-1:0]  o_line;
    logic               o_err_ovf;
    logic               o_busy;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    bit toggle_mode = 0;

    logic [8:0] got_q[$];
    logic [8:0] exp_q[$];
    int         beat_cyc[$];
    int         in_cyc[$];
    bit         ovf_q[$];

    rle_text_decoder #(
        .CHAR_W(CHAR_W), .COUNT_W(COUNT_W), .LINE_W(LINE_W), .MAX_COLS(MAX_COLS)
    ) dut (
        .iclk(iclk), .ireset(ireset),
        .s_valid(s_valid), .s_ready(s_ready), .s_char(s_char),
        .s_count(s_count), .s_eol(s_eol),
        .m_valid(m_valid), .m_ready(m_ready), .m_char(m_char), .m_eol(m_eol),
        .o_col(o_col), .o_line(o_line), .o_err_ovf(o_err_ovf), .o_busy(o_busy)
    );

    initial begin
        iclk = 0;
        forever #5 iclk = ~iclk;
    end

    initial begin
        forever begin
            @(posedge iclk);
            cyc++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Sink pacing: always ready, or toggling every cycle
    initial begin
        m_ready = 1;
        forever begin
            @(posedge iclk);
            #1;
            if (toggle_mode) m_ready = !m_ready;
            else m_ready = 1;
        end
    end

    // Monitor: logs accepted beats/pairs and checks output holds while stalled
    initial begin
        bit         prev_stall;
        logic [8:0] prev_word;
        prev_stall = 0;
        prev_word  = '0;
        forever begin
            @(negedge iclk);
            if (!ireset) begin
                if (prev_stall)
                    check("stall_hold", 32'({m_valid, m_eol, m_char}), 32'({1'b1, prev_word}));
                if (m_valid && m_ready) begin
                    got_q.push_back({m_eol, m_char});
                    beat_cyc.push_back(cyc);
                    ovf_q.push_back(o_err_ovf);
                end
                if (s_valid && s_ready) in_cyc.push_back(cyc);
            end
            prev_stall = m_valid && !m_ready && !ireset;
            prev_word  = {m_eol, m_char};
        end
    end

    task automatic clear_log();
        got_q.delete();
        exp_q.delete();
        beat_cyc.delete();
        in_cyc.delete();
        ovf_q.delete();
    endtask

    task automatic push_run(input logic [7:0] c, input int n, input bit e);
        for (int i = 0; i < n; i++) exp_q.push_back({1'b0, c});
        if (e) exp_q.push_back(9'h10A);
    endtask

    task automatic do_reset();
        ireset = 1;
        s_valid = 0;
        repeat (2) @(posedge iclk);
        @(negedge iclk);
        check("rst_ctl", 32'({s_ready, m_valid, m_eol, o_err_ovf, o_busy, m_char}), 32'h0);
        check("rst_cnt", 32'({o_line, o_col}), 32'h0);
        @(posedge iclk);
        #1 ireset = 0;
        @(negedge iclk);
        check("rst_rdy", 32'(s_ready), 32'h1);
        @(posedge iclk);
        #1;
        clear_log();
    endtask

    task automatic send_pair(input logic [7:0] c, input logic [7:0] n, input bit e);
        int  k;
        bit  done;
        s_char  = c;
        s_count = n;
        s_eol   = e;
        s_valid = 1;
        k = 0;
        done = 0;
        while (!done && k < 600) begin
            @(negedge iclk);
            if (s_ready) done = 1;
            else k++;
        end
        if (!done) begin
            check("s_ready_timeout", 32'h0, 32'h1);
            s_valid = 0;
        end else begin
            @(posedge iclk);
            #1 s_valid = 0;
        end
    endtask

    task automatic wait_beats(input int n, input int budget);
        int k;
        k = 0;
        while (got_q.size() < n && k < budget) begin
            @(posedge iclk);
            k++;
        end
        repeat (3) @(posedge iclk);
        @(negedge iclk);
    endtask

    task automatic compare_stream(input string tag);
        int n;
        check({tag, "_nbeats"}, 32'(got_q.size()), 32'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_beat%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    endtask

    initial begin
        ireset  = 1;
        s_valid = 0;
        s_char  = 0;
        s_count = 0;
        s_eol   = 0;

        // Reset state
        do_reset();

        // Basic line: ('.',3,0) ('#',2,1) -> 2E 2E 2E 23 23 0A back to back
        push_run(8'h2E, 3, 0);
        push_run(8'h23, 2, 1);
        send_pair(8'h2E, 8'd3, 0);
        send_pair(8'h23, 8'd2, 1);
        wait_beats(6, 60);
        compare_stream("basic");
        if (got_q.size() == 6 && in_cyc.size() == 2) begin
            check("basic_latency", 32'(beat_cyc[0]), 32'(in_cyc[0] + 1));
            check("basic_no_bubble", 32'(beat_cyc[5] - beat_cyc[0]), 32'd5);
            check("basic_pair2_at_last", 32'(in_cyc[1]), 32'(beat_cyc[2]));
        end else check("basic_handshakes", 32'(in_cyc.size()), 32'd2);
        check("basic_line_col", 32'({o_line, o_col}), {4'h0, 12'd1, 16'd0});
        check("basic_idle", 32'({m_valid, o_busy, o_err_ovf}), 32'h0);

        // Line join: newline beat blocks input until taken, then next pair is seamless
        @(posedge iclk); #1;
        clear_log();
        push_run(8'h61, 1, 1);
        push_run(8'h62, 1, 0);
        send_pair(8'h61, 8'd1, 1);
        send_pair(8'h62, 8'd1, 0);
        wait_beats(3, 40);
        compare_stream("join");
        if (got_q.size() == 3 && in_cyc.size() == 2) begin
            check("join_pair2_at_nl", 32'(in_cyc[1]), 32'(beat_cyc[1]));
            check("join_no_bubble", 32'(beat_cyc[2] - beat_cyc[0]), 32'd2);
        end else check("join_handshakes", 32'(in_cyc.size()), 32'd2);
        check("join_line_col", 32'({o_line, o_col}), {4'h0, 12'd2, 16'd1});

        // Backpressure: sink toggles; same 6 beats in order, outputs held while stalled
        do_reset();
        toggle_mode = 1;
        push_run(8'h2E, 3, 0);
        push_run(8'h23, 2, 1);
        send_pair(8'h2E, 8'd3, 0);
        send_pair(8'h23, 8'd2, 1);
        wait_beats(6, 80);
        compare_stream("bp");
        if (got_q.size() == 6 && in_cyc.size() == 2)
            check("bp_pair2_at_last", 32'(in_cyc[1]), 32'(beat_cyc[2]));
        else check("bp_handshakes", 32'(in_cyc.size()), 32'd2);
        check("bp_line_col", 32'({o_line, o_col}), {4'h0, 12'd1, 16'd0});
        toggle_mode = 0;
        @(posedge iclk); #1;

        // Zero counts: ('x',0,0) discarded, (' ',0,1) is a lone newline
        do_reset();
        send_pair(8'h78, 8'd0, 0);
        repeat (4) @(posedge iclk);
        @(negedge iclk);
        check("zero_no_beats", 32'(got_q.size()), 32'd0);
        check("zero_ready_idle", 32'({s_ready, o_busy, m_valid}), 32'b100);
        @(posedge iclk); #1;
        exp_q.push_back(9'h10A);
        send_pair(8'h20, 8'd0, 1);
        wait_beats(1, 20);
        compare_stream("empty_line");
        if (got_q.size() == 1 && in_cyc.size() == 2)
            check("empty_line_latency", 32'(beat_cyc[0]), 32'(in_cyc[1] + 1));
        check("empty_line_cnt", 32'({o_line, o_col}), {4'h0, 12'd1, 16'd0});

        // Max run: 255 consecutive '#' then idle
        do_reset();
        push_run(8'h23, 255, 0);
        send_pair(8'h23, 8'd255, 0);
        wait_beats(255, 400);
        compare_stream("maxrun");
        if (got_q.size() == 255)
            check("maxrun_no_bubble", 32'(beat_cyc[254] - beat_cyc[0]), 32'd254);
        check("maxrun_col", 32'(o_col), 32'd255);
        check("maxrun_idle", 32'({m_valid, o_busy}), 32'h0);

        // Overflow: 10 chars with MAX_COLS=8; flag visible from the 10th beat on
        do_reset();
        push_run(8'h2E, 10, 1);
        send_pair(8'h2E, 8'd10, 1);
        wait_beats(11, 40);
        compare_stream("ovf");
        begin
            logic [31:0] ovf_vec;
            ovf_vec = '0;
            for (int i = 0; i < ovf_q.size() && i < 32; i++) ovf_vec[i] = ovf_q[i];
            check("ovf_rise", ovf_vec, 32'h600);
        end
        check("ovf_after_nl", 32'(o_err_ovf), 32'd1);
        @(posedge iclk); #1;
        send_pair(8'h61, 8'd2, 1);
        wait_beats(14, 20);
        check("ovf_sticky", 32'({o_err_ovf, o_line}), {19'h0, 1'b1, 12'd2});
        @(posedge iclk); #1;
        do_reset();
        check("ovf_cleared", 32'(o_err_ovf), 32'd0);

        // Reset mid-run: reset while the 3rd '#' of ('#',5,1) is presented
        send_pair(8'h23, 8'd5, 1);
        begin
            int k;
            k = 0;
            while (got_q.size() < 2 && k < 20) begin
                @(posedge iclk);
                k++;
            end
        end
        #1 ireset = 1;
        @(posedge iclk);
        #1 ireset = 0;
        @(negedge iclk);
        check("midrst_ctl", 32'({m_valid, o_busy, o_err_ovf, m_eol}), 32'h0);
        check("midrst_cnt", 32'({o_line, o_col}), 32'h0);
        check("midrst_beats", 32'(got_q.size()), 32'd2);
        @(posedge iclk); #1;
        clear_log();
        push_run(8'h61, 1, 1);
        send_pair(8'h61, 8'd1, 1);
        wait_beats(2, 20);
        compare_stream("after_rst");
        check("after_rst_cnt", 32'({o_line, o_col}), {4'h0, 12'd1, 16'd0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rle_text_decoder.md
# rle_text_decoder

Expands a run-length-encoded text stream (character, repeat count, end-of-line flag) into a one-character-per-beat output stream with line terminators. It is the synthesizable playback side of the DSP library's text banners: a banner stored compactly as RLE pairs in a ROM or FIFO feeds this block, and the expanded characters go to a UART or debug stream sink. Both sides use valid/ready handshakes, and the output runs at full throughput.

## Interface
- CHAR_W, 8, character width
- COUNT_W, 8, repeat-count width (max run 2^COUNT_W-1)
- LINE_W, 12, line counter width
- MAX_COLS, 128, column limit for overflow flag
- iclk  in  1  clock; all logic on rising edge
- ireset  in  1  synchronous, active-high reset
- s_valid  in  1  RLE pair valid
- s_ready  out  1  RLE pair accepted when s_valid&&s_ready
- s_char  in  CHAR_W  character to repeat
- s_count  in  COUNT_W  repeat count (0 allowed)
- s_eol  in  1  pair ends current line
- m_valid  out  1  output character valid
- m_ready  in  1  sink accepts when m_valid&&m_ready
- m_char  out  CHAR_W  output character
- m_eol  out  1  marks the newline beat (m_char=0x0A)
- o_col  out  16  chars accepted in current line, newline excluded
- o_line  out  LINE_W  newline beats accepted, wraps mod 2^LINE_W
- o_err_ovf  out  1  sticky: char accepted while o_col==MAX_COLS
- o_busy  out  1  state != IDLE

## Operation
- Registers: rem (COUNT_W), char_r, eol_r, output register (m_valid, m_char, m_eol).
- States: IDLE, RUN (repeating char_r), NL (newline beat presented).
- Pair load (from IDLE, or at the final beat of RUN/NL):
  - count>0: char_r=s_char, rem=s_count, eol_r=s_eol, present s_char, go to RUN.
  - count==0 && s_eol: present 0x0A with m_eol=1, go to NL (empty line).
  - count==0 && !s_eol: discard the pair, emit nothing, go to or stay in IDLE.
- RUN, on beat accept (m_valid&&m_ready):
  - rem>1: rem--, present char_r again.
  - rem==1 && eol_r: present 0x0A/m_eol=1, go to NL.
  - rem==1 && !eol_r: load the next pair if s_valid, else m_valid=0, go to IDLE.
- NL, on beat accept: o_line++, o_col=0, then load the next pair if s_valid, else go to IDLE.
- s_ready = (state==IDLE) || (m_valid && m_ready && final beat && the next state is not NL). This path is combinational from m_ready.
- Stall: while m_valid && !m_ready, m_char, m_eol, rem and the counters hold. Beats are never dropped or duplicated.
- o_col increments on every accepted non-newline beat and saturates at 2^16-1. The flag o_err_ovf is set on an accepted non-newline beat with o_col==MAX_COLS. It clears only on reset.

## Timing
- Reset (ireset=1 sampled at an edge): next cycle s_ready=0, m_valid=0, m_char=0, m_eol=0, o_col=0, o_line=0, o_err_ovf=0, o_busy=0, state=IDLE. Any pair being expanded is dropped. s_ready=1 the first cycle after ireset deasserts.
- Latency: a pair accepted at edge k gives its first beat with m_valid=1 in cycle k+1.
- Throughput: with m_ready=1 the block emits one beat per cycle. There are no bubbles between consecutive pairs or across line ends.
- Beat count per pair: s_count characters, plus 1 newline beat if s_eol. A pair with count 0 and eol 0 takes 1 input cycle and produces no output.
- Simultaneous events: when the final beat is accepted and s_valid=1 in the same cycle, the pair is taken and its first beat appears the next cycle. While the newline is pending, s_ready=0 until the NL beat is accepted.

## Test plan
- Basic line: pairs ('.',3,0) then ('#',2,1), m_ready=1 -> m_char sequence 2E,2E,2E,23,23,0A on 6 consecutive cycles. m_eol=1 only on the 6th beat. Afterwards o_line=1, o_col=0.
- Backpressure: same stimulus with m_ready toggling 1,0,1,0 -> m_char is stable while stalled. Exactly 6 accepted beats in the same order. s_ready stays 0 until the final beat is accepted.
- Zero counts: ('x',0,0) -> no output beats and s_ready stays 1. Then (' ',0,1) -> a single 0x0A beat with m_eol=1, o_line increments and o_col stays 0.
- Max run: ('#',255,0) with m_ready=1 -> exactly 255 consecutive beats of 0x23, then m_valid=0. o_col=255.
- Overflow: MAX_COLS=8, pairs ('.',10,1) -> o_err_ovf rises after the 9th character is accepted and stays 1 after the newline and through later lines until ireset.
- Reset mid-run: assert ireset during the 3rd beat of ('#',5,1) -> next cycle m_valid=0 and all counters are 0. After release, a fresh pair ('a',1,1) gives 0x61 then 0x0A, with no leftover '#' beats.
